// File: rtl/rv_pkg.sv
// Shared RV32I constants for the memory stage: funct3 width codes, mcause values,
// major opcodes and the load/store unit state encoding.
package rv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [3:0] MCAUSE_INSN_MIS = 4'd0;
  localparam logic [3:0] MCAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] MCAUSE_LD_MIS   = 4'd4;
  localparam logic [3:0] MCAUSE_LD_FAULT = 4'd5;
  localparam logic [3:0] MCAUSE_ST_MIS   = 4'd6;
  localparam logic [3:0] MCAUSE_ST_FAULT = 4'd7;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/stage_mem_lsu_if.sv
// Wishbone-classic data bus between the load/store unit (master) and memory (slave).
// Signal suffixes are relative to the master.
interface stage_mem_lsu_if;

  logic [31:0] addr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        cyc_o;
  logic        stb_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;

  modport master (
    output addr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  addr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
    output dat_i, ack_i, err_i
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: misalignment detection, byte enables, store-lane replication
// for the incoming request, and load extract/extend for the transfer in flight.
module lsu_align
  import rv_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_d_i,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] ld_raw_i,
  output logic        supported_o,
  output logic        misaligned_o,
  output logic [3:0]  sel_o,
  output logic [31:0] st_lanes_o,
  output logic [31:0] ld_ext_o
);

  logic        mis_raw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Unsupported encodings never raise a misalign flag; the decoder reports them.
  always_comb begin
    if (is_store_i) begin
      supported_o = (funct3_i == F3_SB) || (funct3_i == F3_SH) || (funct3_i == F3_SW);
    end else begin
      supported_o = (funct3_i == F3_LB)  || (funct3_i == F3_LH) || (funct3_i == F3_LW) ||
                    (funct3_i == F3_LBU) || (funct3_i == F3_LHU);
    end
    mis_raw    = 1'b0;
    sel_o      = 4'b1111;
    st_lanes_o = st_d_i;
    case (funct3_i[1:0])
      2'b00: begin
        sel_o      = 4'b0001 << addr_lo_i;
        st_lanes_o = {4{st_d_i[7:0]}};
      end
      2'b01: begin
        mis_raw    = addr_lo_i[0];
        sel_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        st_lanes_o = {2{st_d_i[15:0]}};
      end
      default: mis_raw = (addr_lo_i != 2'b00);
    endcase
    misaligned_o = mis_raw & supported_o;
  end

  always_comb begin
    case (ld_addr_lo_i)
      2'd0:    ld_byte = ld_raw_i[7:0];
      2'd1:    ld_byte = ld_raw_i[15:8];
      2'd2:    ld_byte = ld_raw_i[23:16];
      default: ld_byte = ld_raw_i[31:24];
    endcase
    ld_half = ld_addr_lo_i[1] ? ld_raw_i[31:16] : ld_raw_i[15:0];
    case (ld_funct3_i)
      F3_LB:   ld_ext_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_ext_o = {24'h0, ld_byte};
      F3_LH:   ld_ext_o = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  ld_ext_o = {16'h0, ld_half};
      default: ld_ext_o = ld_raw_i;
    endcase
  end

endmodule

// File: rtl/stage_mem_lsu.sv
// Memory-stage load/store unit: one Wishbone-classic transfer per request, results to write-back.
// Optional bus timeout abort is enabled by defining LSU_BUS_TIMEOUT_EN.
module stage_mem_lsu
  import rv_pkg::*;
`ifdef LSU_BUS_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 255)
`endif
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            is_store_i,
  input  logic [2:0]      funct3_i,
  input  logic [31:0]     addr_i,
  input  logic [31:0]     st_d_i,
  output logic [31:0]     mem_d_o,
  output logic [31:0]     bad_addr_o,
  output logic            e_ld_addr_mis_o,
  output logic            e_st_addr_mis_o,
  output logic            e_ld_fault_o,
  output logic            e_st_fault_o,
  output logic            done_o,
  output logic            stall_o,
  stage_mem_lsu_if.master dwbm
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] mem_d_q, mem_d_d;
  logic [31:0] bad_addr_q, bad_addr_d;
  logic        ld_mis_q, ld_mis_d, st_mis_q, st_mis_d;
  logic        ld_flt_q, ld_flt_d, st_flt_q, st_flt_d;
  logic        bus_end, bus_fault;

  logic        supported, misaligned;
  logic [3:0]  req_sel;
  logic [31:0] st_lanes, ld_ext;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_q, tmo_d;
`endif

  lsu_align u_align (
    .is_store_i   (is_store_i),
    .funct3_i     (funct3_i),
    .addr_lo_i    (addr_i[1:0]),
    .st_d_i       (st_d_i),
    .ld_funct3_i  (f3_q),
    .ld_addr_lo_i (addr_q[1:0]),
    .ld_raw_i     (dwbm.dat_i),
    .supported_o  (supported),
    .misaligned_o (misaligned),
    .sel_o        (req_sel),
    .st_lanes_o   (st_lanes),
    .ld_ext_o     (ld_ext)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    cyc_d      = cyc_q;
    f3_d       = f3_q;
    mem_d_d    = mem_d_q;
    bad_addr_d = bad_addr_q;
    ld_mis_d   = ld_mis_q;
    st_mis_d   = st_mis_q;
    ld_flt_d   = ld_flt_q;
    st_flt_d   = st_flt_q;
    bus_end    = 1'b0;
    bus_fault  = 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
    tmo_d      = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          if (!supported || misaligned) begin
            state_d  = ST_DONE;
            mem_d_d  = '0;
            ld_flt_d = 1'b0;
            st_flt_d = 1'b0;
            ld_mis_d = misaligned & ~is_store_i;
            st_mis_d = misaligned & is_store_i;
            if (misaligned) begin
              bad_addr_d = addr_i;
            end
          end else begin
            state_d = ST_BUS;
            addr_d  = addr_i;
            wdat_d  = st_lanes;
            sel_d   = req_sel;
            we_d    = is_store_i;
            f3_d    = funct3_i;
            cyc_d   = 1'b1;
          end
        end
      end
      ST_BUS: begin
        // err takes priority over a simultaneous ack; the read data is dropped.
        if (dwbm.err_i) begin
          bus_end   = 1'b1;
          bus_fault = 1'b1;
        end else if (dwbm.ack_i) begin
          bus_end = 1'b1;
        end
`ifdef LSU_BUS_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          bus_end   = 1'b1;
          bus_fault = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
        if (bus_end) begin
          state_d  = ST_DONE;
          cyc_d    = 1'b0;
          we_d     = 1'b0;
          sel_d    = 4'b0000;
          ld_mis_d = 1'b0;
          st_mis_d = 1'b0;
          ld_flt_d = bus_fault & ~we_q;
          st_flt_d = bus_fault & we_q;
          mem_d_d  = (bus_fault || we_q) ? 32'h0 : ld_ext;
          if (bus_fault) begin
            bad_addr_d = addr_q;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdat_q     <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      cyc_q      <= 1'b0;
      f3_q       <= '0;
      mem_d_q    <= '0;
      bad_addr_q <= '0;
      ld_mis_q   <= 1'b0;
      st_mis_q   <= 1'b0;
      ld_flt_q   <= 1'b0;
      st_flt_q   <= 1'b0;
`ifdef LSU_BUS_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      cyc_q      <= cyc_d;
      f3_q       <= f3_d;
      mem_d_q    <= mem_d_d;
      bad_addr_q <= bad_addr_d;
      ld_mis_q   <= ld_mis_d;
      st_mis_q   <= st_mis_d;
      ld_flt_q   <= ld_flt_d;
      st_flt_q   <= st_flt_d;
`ifdef LSU_BUS_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign done_o          = (state_q == ST_DONE);
  assign stall_o         = ((state_q == ST_IDLE) && req_i) || (state_q == ST_BUS);
  assign mem_d_o         = mem_d_q;
  assign bad_addr_o      = bad_addr_q;
  assign e_ld_addr_mis_o = ld_mis_q;
  assign e_st_addr_mis_o = st_mis_q;
  assign e_ld_fault_o    = ld_flt_q;
  assign e_st_fault_o    = st_flt_q;

  assign dwbm.addr_o = {addr_q[31:2], 2'b00};
  assign dwbm.dat_o  = wdat_q;
  assign dwbm.sel_o  = sel_q;
  assign dwbm.we_o   = we_q;
  assign dwbm.cyc_o  = cyc_q;
  assign dwbm.stb_o  = cyc_q;

endmodule

// File: tb/tb_stage_mem_lsu.sv
// Self-checking bench for stage_mem_lsu: directed transactions against a byte-level
// behavioural model, checked every cycle by one monitor process.
module tb_stage_mem_lsu;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  typedef struct packed {
    logic        isStore;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] std;
    logic [31:0] rdata;
    logic [3:0]  waitSt;
    logic        ack;
    logic        err;
    logic        noisy;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        isStore;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] stD;
  logic [31:0] memD;
  logic [31:0] badAddr;
  logic        ldMis, stMis, ldFlt, stFlt, done, stall;

  stage_mem_lsu_if bus();

`ifdef LSU_BUS_TIMEOUT_EN
  stage_mem_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
`else
  stage_mem_lsu dut (
`endif
    .clk_i           (clk),
    .rst_i           (rst),
    .req_i           (req),
    .is_store_i      (isStore),
    .funct3_i        (funct3),
    .addr_i          (addr),
    .st_d_i          (stD),
    .mem_d_o         (memD),
    .bad_addr_o      (badAddr),
    .e_ld_addr_mis_o (ldMis),
    .e_st_addr_mis_o (stMis),
    .e_ld_fault_o    (ldFlt),
    .e_st_fault_o    (stFlt),
    .done_o          (done),
    .stall_o         (stall),
    .dwbm            (bus)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // expectations produced by the model for the transaction in flight
  bit          monEn = 1'b0;
  int          curCycle;
  int          expDone;
  bit          busUsed;
  logic [31:0] expAddr, expDat, expMemD, expBad;
  logic [3:0]  expSel;
  logic        expWe, expLdMis, expStMis, expLdFlt, expStFlt, expBadValid;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rd, input logic [3:0] w,
                              input logic ak, input logic er, input logic nz);
    txn_t t;
    t.isStore = st; t.f3 = f3; t.addr = a; t.std = sd; t.rdata = rd;
    t.waitSt = w; t.ack = ak; t.err = er; t.noisy = nz;
    return t;
  endfunction

  // Byte-level model: access width in bytes, byte offset, mask-and-extend.
  task automatic modelTxn(input txn_t t);
    int w, off;
    bit supp, mis, fault;
    logic [31:0] mask, v;
    w    = (t.f3[1:0] == 2'b00) ? 1 : (t.f3[1:0] == 2'b01) ? 2 : 4;
    supp = t.isStore ? (t.f3 <= 3'd2) : (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    off  = int'(t.addr % 4);
    mis  = supp && ((t.addr % w) != 0);
    busUsed = supp && !mis;
    fault   = busUsed && (t.err || !t.ack);
    expDone = !busUsed ? 1 : ((t.ack || t.err) ? 2 + int'(t.waitSt) : 1 + TMO);
    expAddr = t.addr - off;
    expWe   = t.isStore;
    expSel  = 4'(((1 << w) - 1) << off);
    for (int i = 0; i < 4; i++) expDat[8*i +: 8] = t.std[8*(i % w) +: 8];
    mask = (w == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*w)) - 1);
    v    = (t.rdata >> (8*off)) & mask;
    if (!t.f3[2] && w < 4 && v[8*w-1]) v = v | ~mask;
    expMemD     = (!t.isStore && busUsed && !fault) ? v : 32'h0;
    expLdMis    = mis && !t.isStore;
    expStMis    = mis && t.isStore;
    expLdFlt    = fault && !t.isStore;
    expStFlt    = fault && t.isStore;
    expBadValid = mis || fault;
    expBad      = t.addr;
  endtask

  always @(negedge clk) begin : monitor
    bit expCyc;
    if (monEn) begin
      expCyc = busUsed && curCycle >= 1 && curCycle < expDone;
      checkOutput("done_o", 32'(done), 32'(curCycle == expDone));
      checkOutput("stall_o", 32'(stall), 32'((curCycle == 0) || expCyc));
      checkOutput("cyc_o", 32'(bus.cyc_o), 32'(expCyc));
      checkOutput("stb_o", 32'(bus.stb_o), 32'(expCyc));
      if (expCyc) begin
        checkOutput("addr_o", bus.addr_o, expAddr);
        checkOutput("sel_o", 32'(bus.sel_o), 32'(expSel));
        checkOutput("we_o", 32'(bus.we_o), 32'(expWe));
        if (expWe) checkOutput("dat_o", bus.dat_o, expDat);
      end
      if (curCycle == expDone) begin
        checkOutput("mem_d_o", memD, expMemD);
        checkOutput("ld_mis", 32'(ldMis), 32'(expLdMis));
        checkOutput("st_mis", 32'(stMis), 32'(expStMis));
        checkOutput("ld_fault", 32'(ldFlt), 32'(expLdFlt));
        checkOutput("st_fault", 32'(stFlt), 32'(expStFlt));
        if (expBadValid) checkOutput("bad_addr_o", badAddr, expBad);
      end
    end
  end

  task automatic applyStimulus(input txn_t t);
    modelTxn(t);
    @(posedge clk); #1;
    for (int c = 0; c <= expDone + 1; c++) begin
      curCycle = c;
      req = (c == 0) || (t.noisy && c >= 1 && c <= expDone);
      if (c == 0) begin
        isStore = t.isStore; funct3 = t.f3; addr = t.addr; stD = t.std;
      end else if (t.noisy) begin
        isStore = 1'b1; funct3 = 3'b010; addr = 32'h0000_0555; stD = 32'h1111_2222;
      end
      bus.dat_i = t.rdata;
      bus.ack_i = busUsed && t.ack && (c == 1 + int'(t.waitSt));
      bus.err_i = busUsed && t.err && (c == 1 + int'(t.waitSt));
      monEn = 1'b1;
      @(posedge clk); #1;
    end
    monEn = 1'b0;
    req = 1'b0; bus.ack_i = 1'b0; bus.err_i = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_done"}, 32'(done), 32'h0);
    checkOutput({tag, "_stall"}, 32'(stall), 32'h0);
    checkOutput({tag, "_cyc"}, 32'(bus.cyc_o), 32'h0);
    checkOutput({tag, "_stb"}, 32'(bus.stb_o), 32'h0);
    checkOutput({tag, "_we"}, 32'(bus.we_o), 32'h0);
    checkOutput({tag, "_sel"}, 32'(bus.sel_o), 32'h0);
    checkOutput({tag, "_addr"}, bus.addr_o, 32'h0);
    checkOutput({tag, "_dat"}, bus.dat_o, 32'h0);
    checkOutput({tag, "_memd"}, memD, 32'h0);
    checkOutput({tag, "_bad"}, badAddr, 32'h0);
    checkOutput({tag, "_flags"}, {28'h0, ldMis, stMis, ldFlt, stFlt}, 32'h0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; req = 1'b0; isStore = 1'b0; funct3 = 3'b0; addr = '0; stD = '0;
    bus.dat_i = '0; bus.ack_i = 1'b0; bus.err_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkIdleOutputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("post_reset");

    applyStimulus(mk(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 4'd1, 1'b1, 1'b0, 1'b0));
    checkOutput("pin_lw_memd", expMemD, 32'hDEAD_BEEF);
    checkOutput("pin_lw_done", 32'(expDone), 32'd3);
    checkOutput("pin_lw_sel", 32'(expSel), 32'hF);
    applyStimulus(mk(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 4'd0, 1'b1, 1'b0, 1'b0));
    checkOutput("pin_lb_memd", expMemD, 32'hFFFF_FF80);
    checkOutput("pin_lb_sel", 32'(expSel), 32'h8);
    applyStimulus(mk(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 4'd0, 1'b1, 1'b0, 1'b0));
    checkOutput("pin_lbu_memd", expMemD, 32'h0000_0080);
    applyStimulus(mk(1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 4'd2, 1'b1, 1'b0, 1'b1));
    checkOutput("pin_sh_dat", expDat, 32'hABCD_ABCD);
    checkOutput("pin_sh_sel", 32'(expSel), 32'hC);
    applyStimulus(mk(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0));
    checkOutput("pin_lwmis_done", 32'(expDone), 32'd1);
    applyStimulus(mk(1'b1, 3'b001, 32'h003, 32'h5555, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0));
    applyStimulus(mk(1'b0, 3'b010, 32'h200, 32'h0, 32'h1234_5678, 4'd0, 1'b1, 1'b1, 1'b0));
    applyStimulus(mk(1'b1, 3'b000, 32'h101, 32'h0000_005A, 32'h0, 4'd1, 1'b1, 1'b0, 1'b0));
    checkOutput("pin_sb_dat", expDat, 32'h5A5A_5A5A);
    applyStimulus(mk(1'b0, 3'b001, 32'h106, 32'h0, 32'h8001_1234, 4'd0, 1'b1, 1'b0, 1'b0));
    checkOutput("pin_lh_memd", expMemD, 32'hFFFF_8001);
    applyStimulus(mk(1'b0, 3'b101, 32'h104, 32'h0, 32'h8001_F00F, 4'd3, 1'b1, 1'b0, 1'b0));
    applyStimulus(mk(1'b1, 3'b010, 32'h010, 32'hCAFE_F00D, 32'h0, 4'd3, 1'b0, 1'b1, 1'b0));
    applyStimulus(mk(1'b0, 3'b011, 32'h108, 32'h0, 32'hFFFF_FFFF, 4'd0, 1'b1, 1'b0, 1'b0));
    applyStimulus(mk(1'b1, 3'b100, 32'h10C, 32'h1, 32'h0, 4'd0, 1'b1, 1'b0, 1'b0));
    applyStimulus(mk(1'b0, 3'b000, 32'h000, 32'h0, 32'hAAAA_AA7F, 4'd0, 1'b1, 1'b0, 1'b0));
    checkOutput("pin_lb0_memd", expMemD, 32'h0000_007F);

    // reset while the bus cycle is open; a late ack must not complete anything
    @(posedge clk); #1;
    req = 1'b1; isStore = 1'b0; funct3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_cyc_before", 32'(bus.cyc_o), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; bus.ack_i = 1'b1; bus.dat_i = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rstmid_cyc", 32'(bus.cyc_o), 32'h0);
      checkOutput("rstmid_done", 32'(done), 32'h0);
      checkOutput("rstmid_stall", 32'(stall), 32'h0);
      @(posedge clk); #1;
    end
    bus.ack_i = 1'b0;

    applyStimulus(mk(1'b0, 3'b010, 32'h500, 32'h0, 32'h0BAD_CAFE, 4'd0, 1'b1, 1'b0, 1'b0));

`ifdef LSU_BUS_TIMEOUT_EN
    applyStimulus(mk(1'b1, 3'b010, 32'h300, 32'h1, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0));
    checkOutput("pin_tmo_done", 32'(expDone), 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/stage_mem_lsu.md
Name: stage_mem_lsu

Overview:
- Load/store unit of the memory stage. It accepts one load or store per request from execute (address from the ALU, store data, funct3) and runs a single Wishbone-classic transfer on the data bus.
- It returns aligned, sign- or zero-extended load data to write-back.
- It is the producer of the write-back stage's mem_d, e_ld_addr_mis, e_st_addr_mis and fault-address inputs.
- Misaligned accesses never reach the bus. Bus errors become access-fault flags.

Parameters:
- TIMEOUT_CYCLES, 255, bus cycles without ack/err before forced abort (used only with LSU_BUS_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  1  memory instruction present this cycle
- is_store_i  in  1  1 = store, 0 = load
- funct3_i  in  3  RV32I width/sign code
- addr_i  in  32  effective address
- st_d_i  in  32  store data (rs2)
- mem_d_o  out  32  extended load data
- bad_addr_o  out  32  faulting address (mtval source)
- e_ld_addr_mis_o  out  1  load misaligned (mcause 4)
- e_st_addr_mis_o  out  1  store misaligned (mcause 6)
- e_ld_fault_o  out  1  load access fault (mcause 5)
- e_st_fault_o  out  1  store access fault (mcause 7)
- done_o  out  1  one-cycle result-valid pulse
- stall_o  out  1  hold upstream pipeline
- dwbm_addr_o  out  32  word address, low 2 bits zero
- dwbm_dat_o  out  32  write data, lane-replicated
- dwbm_sel_o  out  4  byte enables
- dwbm_we_o  out  1  write enable
- dwbm_cyc_o  out  1  cycle
- dwbm_stb_o  out  1  strobe
- dwbm_dat_i  in  32  read data
- dwbm_ack_i  in  1  ack
- dwbm_err_i  in  1  error

Behaviour:
- Reset: state IDLE. All outputs 0, including all dwbm_* outputs and mem_d_o.
- FSM states: IDLE, BUS, DONE.
- IDLE, req_i=1:
  - Address aligned: latch address, we, sel, data and funct3; go to BUS.
  - Misaligned: latch flag and bad_addr; go to DONE with no bus activity.
- BUS:
  - cyc/stb/we/sel/addr/dat are registered and held stable until ack or err.
  - ack: capture dat_i; go to DONE.
  - err: set the fault flag; go to DONE.
  - ack and err in the same cycle: err wins; data is discarded.
- DONE: done_o=1 for exactly one cycle, together with mem_d_o and the flags. Then IDLE.
- Flags and bad_addr_o are held until the next done_o and are qualified by done_o.
- stall_o = (IDLE & req_i) | BUS. It is 0 in DONE.
- Latency:
  - Bus ack at cycle k after acceptance (cycle 0) gives done_o at cycle k+1.
  - A zero-wait slave gives done_o at cycle 2.
  - A misaligned access gives done_o at cycle 1.
- Alignment rules:
  - Halfword is misaligned if addr[0]=1.
  - Word is misaligned if addr[1:0]≠0.
  - Byte is never misaligned.
- sel:
  - SB: 1<<addr[1:0].
  - SH: 0011 or 1100.
  - SW/LW: 1111.
  - Loads use the same sel as stores of the same width.
- Store data: byte replicated ×4; half replicated ×2.
- Load extraction: select the lane by addr[1:0].
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes through.
- Unsupported funct3 (loads 011/110/111, stores ≥011): done_o on the next cycle, no bus access, no flag. The decoder owns illegal-instruction reporting.
- mem_d_o is 0 on every non-load completion.
- Reset mid-transfer: cyc/stb drop at that edge, state goes to IDLE, and a late ack is ignored.
- A new req_i is ignored outside IDLE.

Optional Feature:
- LSU_BUS_TIMEOUT_EN defined:
  - A counter runs in BUS.
  - After TIMEOUT_CYCLES cycles without ack/err: cyc/stb drop, fault flag is set, go to DONE.
- Not defined: BUS waits indefinitely, and no counter logic is generated.

Decomposition:
- Shared package rv_pkg holds:
  - funct3 codes (LB/LH/LW/LBU/LHU/SB/SH/SW);
  - mcause codes 0/2/4/5/6/7;
  - opcodes LOAD/STORE/OP/SYSTEM;
  - FSM state encoding.
- One natural sub-module: lsu_align, purely combinational. It produces misalign detection, sel, store-lane replication and load extract/extend.

Test Plan:
- Aligned load: LW addr 0x100, slave returns 0xDEADBEEF with ack at 1 wait state → sel=1111, addr 0x100, done_o at cycle 3, mem_d_o=0xDEADBEEF.
- Byte extension: LB addr 0x103, dat_i 0x80FF_0000 → sel=1000, mem_d_o=0xFFFFFF80. LBU at the same address → 0x00000080.
- Store lanes: SH addr 0x202, st_d 0x1234ABCD → sel=1100, dat_o=0xABCDABCD, we=1, done_o after ack, no flags.
- Misaligned accesses: LW 0x101 → no cyc, done_o at cycle 1, e_ld_addr_mis_o=1, bad_addr_o=0x101. SH 0x003 → e_st_addr_mis_o=1.
- Bus error: LW with err and ack in the same cycle → e_ld_fault_o=1, mem_d_o=0. rst_i asserted in BUS → cyc=0 next cycle, a later ack produces no done_o.
- Timeout (LSU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4): no ack → cyc drops after 4 BUS cycles, e_st_fault_o=1 for a store.
